multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle control unit for the datapath.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 39 +++
 rtl/multicycle_ctrl_fsm_opdecode.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state codes and the
// ALU operand/operation and PC-source mux selects.
package multicycle_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      LW_RD     = 4'd3,
      LW_WB     = 4'd4,
      SW_WR     = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      EXC       = 4'd12
   } ctrlState_t;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_EPC   = 2'd3;

   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH  = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_EXC    = 2'd3;

   localparam logic CAUSE_UNDEF = 1'b0;
   localparam logic CAUSE_OVFL  = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_fsm_opdecode.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module multicycle_ctrl_fsm_opdecode #(
   parameter int OP_W     = 6,
   parameter int OP_RTYPE = 0,
   parameter int OP_J     = 2,
   parameter int OP_BEQ   = 4,
   parameter int OP_ADDI  = 8,
   parameter int OP_LW    = 35,
   parameter int OP_SW    = 43
) (
   input  logic [OP_W-1:0] op,
   output logic            isR,
   output logic            isJ,
   output logic            isBeq,
   output logic            isAddi,
   output logic            isLw,
   output logic            isSw,
   output logic            illegal
);

   localparam logic [OP_W-1:0] OPC_R    = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] OPC_J    = OP_W'(OP_J);
   localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(OP_ADDI);
   localparam logic [OP_W-1:0] OPC_LW   = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] OPC_SW   = OP_W'(OP_SW);

   assign isR     = (op == OPC_R);
   assign isJ     = (op == OPC_J);
   assign isBeq   = (op == OPC_BEQ);
   assign isAddi  = (op == OPC_ADDI);
   assign isLw    = (op == OPC_LW);
   assign isSw    = (op == OPC_SW);
   assign illegal = ~(isR | isJ | isBeq | isAddi | isLw | isSw);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on memory
// and vectors to the exception handler on overflow or undefined opcode.
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int STATE_W  = 4,
   parameter int OP_RTYPE = 0,
   parameter int OP_J     = 2,
   parameter int OP_BEQ   = 4,
   parameter int OP_ADDI  = 8,
   parameter int OP_LW    = 35,
   parameter int OP_SW    = 43,
   parameter int MEM_HS   = 1
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [OP_W-1:0]    op,
   input  logic               ovfl,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               EPCWrite,
   output logic               CauseWrite,
   output logic               IntCause,
   output logic [STATE_W-1:0] current_state,
   output logic [STATE_W-1:0] next_state
);

   ctrlState_t state;
   ctrlState_t nextState;
   logic       intCauseQ;
   logic       causeLoad;
   logic       causeNext;
   logic       memRdy;
   logic       isR, isJ, isBeq, isAddi, isLw, isSw, illegal;

   multicycle_ctrl_fsm_opdecode #(
      .OP_W    (OP_W),
      .OP_RTYPE(OP_RTYPE),
      .OP_J    (OP_J),
      .OP_BEQ  (OP_BEQ),
      .OP_ADDI (OP_ADDI),
      .OP_LW   (OP_LW),
      .OP_SW   (OP_SW)
   ) uOpDecode (
      .op     (op),
      .isR    (isR),
      .isJ    (isJ),
      .isBeq  (isBeq),
      .isAddi (isAddi),
      .isLw   (isLw),
      .isSw   (isSw),
      .illegal(illegal)
   );

   assign memRdy = (MEM_HS == 0) ? 1'b1 : mem_ready;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= FETCH;
         intCauseQ <= CAUSE_UNDEF;
      end else begin
         state <= nextState;
         if (causeLoad)
            intCauseQ <= causeNext;
      end
   end

   // Outputs are forced low while Reset is held so a stalled strobe drops at once.
   always_comb begin
      nextState   = FETCH;
      causeLoad   = 1'b0;
      causeNext   = intCauseQ;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      EPCWrite    = 1'b0;
      CauseWrite  = 1'b0;
      if (!Reset) begin
         case (state)
            FETCH: begin
               MemRead   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               IRWrite   = memRdy;
               PCWrite   = memRdy;
               nextState = memRdy ? DECODE : FETCH;
            end
            DECODE: begin
               ALUSrcB = SRCB_IMMSH;
               if (illegal) begin
                  nextState = EXC;
                  causeLoad = 1'b1;
                  causeNext = CAUSE_UNDEF;
               end
               else if (isR)    nextState = R_EXEC;
               else if (isJ)    nextState = JUMP;
               else if (isBeq)  nextState = BRANCH;
               else if (isAddi) nextState = ADDI_EXEC;
               else             nextState = MEM_ADDR;
            end
            MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               if (isLw)      nextState = LW_RD;
               else if (isSw) nextState = SW_WR;
               else           nextState = FETCH;
            end
            LW_RD: begin
               MemRead   = 1'b1;
               IorD      = 1'b1;
               nextState = memRdy ? LW_WB : LW_RD;
            end
            LW_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            SW_WR: begin
               MemWrite  = 1'b1;
               IorD      = 1'b1;
               nextState = memRdy ? FETCH : SW_WR;
            end
            R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
               if (ovfl) begin
                  nextState = EXC;
                  causeLoad = 1'b1;
                  causeNext = CAUSE_OVFL;
               end else begin
                  nextState = R_WB;
               end
            end
            R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            ADDI_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               if (ovfl) begin
                  nextState = EXC;
                  causeLoad = 1'b1;
                  causeNext = CAUSE_OVFL;
               end else begin
                  nextState = ADDI_WB;
               end
            end
            ADDI_WB: begin
               RegWrite = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = PCSRC_JUMP;
            end
            EXC: begin
               ALUSrcB    = SRCB_FOUR;
               ALUOp      = ALUOP_EPC;
               EPCWrite   = 1'b1;
               CauseWrite = 1'b1;
               PCWrite    = 1'b1;
               PCSource   = PCSRC_EXC;
            end
            default: nextState = FETCH;
         endcase
      end
   end

   assign IntCause      = intCauseQ;
   assign current_state = STATE_W'(state);
   assign next_state    = STATE_W'(nextState);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed reset/trace checks, then random
// instructions scored per instruction against an instruction-level model.
module tb_multicycle_ctrl_fsm;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] op;
   logic       ovfl;
   logic       memReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA, EPCWrite, CauseWrite, IntCause;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] curState, nxtState;

   logic       reset2;
   logic       u2PCWrite, u2PCWriteCond, u2IorD, u2MemRead, u2MemWrite, u2IRWrite;
   logic       u2RegDst, u2MemtoReg, u2RegWrite, u2ALUSrcA, u2EPCWrite, u2CauseWrite, u2IntCause;
   logic [1:0] u2ALUSrcB, u2ALUOp, u2PCSource;
   logic [3:0] u2CurState, u2NxtState;

   int nChecks = 0;
   int nFail   = 0;

   always #5 CLK = ~CLK;

   multicycle_ctrl_fsm dut (
      .CLK(CLK), .Reset(Reset), .op(op), .ovfl(ovfl), .mem_ready(memReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
      .IntCause(IntCause), .current_state(curState), .next_state(nxtState)
   );

   multicycle_ctrl_fsm #(.MEM_HS(0)) dutNoHs (
      .CLK(CLK), .Reset(reset2), .op(6'd43), .ovfl(1'b0), .mem_ready(1'b0),
      .PCWrite(u2PCWrite), .PCWriteCond(u2PCWriteCond), .IorD(u2IorD), .MemRead(u2MemRead),
      .MemWrite(u2MemWrite), .IRWrite(u2IRWrite), .RegDst(u2RegDst), .MemtoReg(u2MemtoReg),
      .RegWrite(u2RegWrite), .ALUSrcA(u2ALUSrcA), .ALUSrcB(u2ALUSrcB), .ALUOp(u2ALUOp),
      .PCSource(u2PCSource), .EPCWrite(u2EPCWrite), .CauseWrite(u2CauseWrite),
      .IntCause(u2IntCause), .current_state(u2CurState), .next_state(u2NxtState)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Instruction-level summary: what one instruction does from fetch to retire.
   typedef struct {
      int cycles;
      int regWrites;
      int regDst;
      int memtoReg;
      int memWrCyc;
      int memRdCyc;
      int excCyc;
      int cause;
      int branchCyc;
   } instRec_t;

   instRec_t expQ[$];

   function automatic instRec_t modelInst(input int cls, input bit ov, input int fw, input int dw);
      instRec_t r;
      r = '{cycles: 0, regWrites: 0, regDst: 0, memtoReg: 0, memWrCyc: 0,
            memRdCyc: 0, excCyc: 0, cause: 0, branchCyc: 0};
      case (cls)
         0, 3: begin
            r.cycles = 4 + fw;
            if (ov) begin r.excCyc = 1; r.cause = 1; end
            else begin r.regWrites = 1; r.regDst = (cls == 0) ? 1 : 0; end
         end
         1: r.cycles = 3 + fw;
         2: begin r.cycles = 3 + fw; r.branchCyc = 1; end
         4: begin
            r.cycles = 5 + fw + dw; r.regWrites = 1; r.memtoReg = 1; r.memRdCyc = dw + 1;
         end
         5: begin r.cycles = 4 + fw + dw; r.memWrCyc = dw + 1; end
         default: begin r.cycles = 3 + fw; r.excCyc = 1; r.cause = 0; end
      endcase
      return r;
   endfunction

   // Random driver doubling as a memory model with per-access wait states.
   bit modelOn = 0, monOn = 0, genDone = 0, allDone = 0;
   bit busy = 0, accDone = 0;
   int cnt = 0, curDw = 0, nGen = 0;
   localparam int N_INST = 80;

   always @(negedge CLK) begin
      if (modelOn && !genDone) begin
         if (accDone) begin busy = 0; accDone = 0; end
         if (MemRead || MemWrite) begin
            if (!busy) begin
               busy = 1;
               if (!IorD) begin
                  if (nGen == N_INST) begin
                     genDone = 1;
                     cnt = 1000;
                  end else begin
                     int cls, fw;
                     bit ov;
                     logic [5:0] opv;
                     cls   = $urandom_range(0, 6);
                     ov    = ($urandom_range(0, 2) == 0);
                     fw    = $urandom_range(0, 3);
                     curDw = $urandom_range(0, 3);
                     case (cls)
                        0: opv = 6'd0;
                        1: opv = 6'd2;
                        2: opv = 6'd4;
                        3: opv = 6'd8;
                        4: opv = 6'd35;
                        5: opv = 6'd43;
                        default: begin
                           opv = ($urandom_range(0, 1) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
                           while (opv == 0 || opv == 2 || opv == 4 || opv == 8 || opv == 35 || opv == 43)
                              opv = 6'($urandom_range(0, 63));
                        end
                     endcase
                     op   = opv;
                     ovfl = ov;
                     cnt  = fw;
                     expQ.push_back(modelInst(cls, ov, fw, curDw));
                     nGen++;
                  end
               end else begin
                  cnt = curDw;
               end
            end
            memReady = (cnt == 0);
            if (cnt > 0) cnt--;
            if (memReady) accDone = 1;
         end else begin
            memReady = 1'($urandom_range(0, 1));
         end
      end else if (genDone) begin
         memReady = 1'b0;
      end
   end

   // Monitor: accumulates each instruction's observed behaviour and retires it at the next fetch.
   bit prevFetch = 0, open = 0;
   instRec_t obs;
   bit excOk;

   always @(negedge CLK) begin
      #3;
      if (monOn && !allDone) begin
         bit isFetch;
         isFetch = MemRead && !IorD;
         if (isFetch && !prevFetch) begin
            if (open) begin
               if (expQ.size() == 0) begin
                  nChecks++;
                  nFail++;
                  $display("FAIL retire: instruction retired with no expectation queued");
               end else begin
                  instRec_t e;
                  e = expQ.pop_front();
                  chk("cycles", obs.cycles, e.cycles);
                  chk("regWrites", obs.regWrites, e.regWrites);
                  if (e.regWrites == 1) begin
                     chk("RegDst at write", obs.regDst, e.regDst);
                     chk("MemtoReg at write", obs.memtoReg, e.memtoReg);
                  end
                  chk("MemWrite cycles", obs.memWrCyc, e.memWrCyc);
                  chk("data MemRead cycles", obs.memRdCyc, e.memRdCyc);
                  chk("exception cycles", obs.excCyc, e.excCyc);
                  if (e.excCyc == 1) begin
                     chk("IntCause", obs.cause, e.cause);
                     chk("exception vector controls", 32'(excOk), 1);
                  end
                  chk("PCWriteCond cycles", obs.branchCyc, e.branchCyc);
               end
            end
            if (genDone) begin
               allDone = 1;
               open = 0;
            end else begin
               open = 1;
               excOk = 1;
               obs = '{cycles: 0, regWrites: 0, regDst: 0, memtoReg: 0, memWrCyc: 0,
                       memRdCyc: 0, excCyc: 0, cause: 0, branchCyc: 0};
            end
         end
         if (open) begin
            obs.cycles++;
            if (RegWrite) begin obs.regWrites++; obs.regDst = RegDst; obs.memtoReg = MemtoReg; end
            if (MemWrite) obs.memWrCyc++;
            if (MemRead && IorD) obs.memRdCyc++;
            if (PCWriteCond) obs.branchCyc++;
            if (EPCWrite) begin
               obs.excCyc++;
               obs.cause = IntCause;
               excOk = excOk && CauseWrite && PCWrite && (PCSource == 2'd3) && (ALUOp == 2'd3);
            end
         end
         prevFetch = isFetch;
      end
   end

   // Memory-handshake-disabled instance: a store must take exactly 0,1,2,5,0.
   initial begin
      int expTrace[5] = '{0, 1, 2, 5, 0};
      int wrCount;
      wrCount = 0;
      reset2 = 1'b1;
      #16 reset2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         #3;
         chk($sformatf("no-handshake SW state[%0d]", i), u2CurState, expTrace[i]);
         if (u2MemWrite) wrCount++;
      end
      chk("no-handshake MemWrite cycles", wrCount, 1);
   end

   initial begin
      Reset = 1'b1; op = 6'd0; ovfl = 1'b0; memReady = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset state", curState, 0);
      chk("reset IntCause", IntCause, 0);
      chk("reset MemRead", MemRead, 0);
      chk("reset IRWrite", IRWrite, 0);
      Reset = 1'b0; op = 6'd35; memReady = 1'b1;
      #1;
      chk("fetch IRWrite mealy", IRWrite, 1);
      chk("fetch PCWrite mealy", PCWrite, 1);
      @(posedge CLK); #1;
      chk("LW decode state", curState, 1);
      chk("LW decode next_state", nxtState, 2);
      @(posedge CLK); #1;
      chk("LW mem_addr state", curState, 2);
      @(posedge CLK); #1;
      chk("LW_RD state", curState, 3);
      memReady = 1'b0;
      @(posedge CLK); #1;
      chk("LW_RD held", curState, 3);
      chk("LW_RD MemRead", MemRead, 1);
      Reset = 1'b1;
      #1;
      chk("mid-wait reset MemRead", MemRead, 0);
      chk("mid-wait reset state", curState, 0);
      @(posedge CLK); #1;
      Reset = 1'b0; memReady = 1'b1;
      #1;
      chk("post-reset state", curState, 0);
      chk("post-reset IRWrite", IRWrite, 1);
      @(posedge CLK); #1;
      chk("post-reset decode", curState, 1);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("LW_WB state", curState, 4);
      chk("LW_WB MemtoReg", MemtoReg, 1);
      chk("LW_WB RegWrite", RegWrite, 1);
      @(posedge CLK); #1;
      chk("LW back to fetch", curState, 0);
      op = 6'd0;
      for (int i = 0; i < 4; i++) begin
         int expS[4] = '{1, 6, 7, 0};
         @(posedge CLK); #1;
         chk($sformatf("R trace[%0d]", i), curState, expS[i]);
         chk($sformatf("R RegWrite[%0d]", i), RegWrite, (expS[i] == 7) ? 1 : 0);
         if (expS[i] == 7) chk("R_WB RegDst", RegDst, 1);
      end

      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
      modelOn = 1;
      monOn = 1;
      for (int c = 0; c < 20000 && !allDone; c++) @(posedge CLK);
      if (!allDone) begin
         nChecks++;
         nFail++;
         $display("FAIL timeout: random phase did not retire %0d instructions", N_INST);
      end
      chk("leftover expectations", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
